bcd_scan_counter: RTL and testbench

//   Parametrised N-digit BCD up/down counter with a built-in multiplexed 7-segment scan driver.
//   A runtime-programmable prescaler paces counting; loadable preset, wrap pulse, debug square wave.

---
 rtl/bcd_scan_counter.sv | 186 ++++++++++++++++++
 tb/tb_bcd_scan_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: N-digit BCD up/down counter, prescaled, with a multiplexed 7-segment scan (LEADING_ZERO_BLANK_EN blanks leading zeros).
// Latency: count/tick/wrap update on the prescaler terminal edge; sel/seg are registered and trail the count by one clock.
// Backpressure: none; en only freezes the prescaler and counter, the scan always runs.
module bcd_scan_counter #(
  parameter int N_DIGITS = 4,
  parameter int CYCLE_W  = 32,
  parameter int SEG_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  input  logic [CYCLE_W-1:0]    cycle,
  input  logic [SEG_W-1:0]      segtiming,
  output logic [4*N_DIGITS-1:0] count,
  output logic                  tick,
  output logic                  wrap,
  output logic                  debug,
  output logic [N_DIGITS-1:0]   sel,
  output logic [7:0]            seg
);

  localparam int               IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    logic [7:0] pattern;
    case (digit)
      4'd0:    pattern = 8'h3F;
      4'd1:    pattern = 8'h06;
      4'd2:    pattern = 8'h5B;
      4'd3:    pattern = 8'h4F;
      4'd4:    pattern = 8'h66;
      4'd5:    pattern = 8'h6D;
      4'd6:    pattern = 8'h7D;
      4'd7:    pattern = 8'h07;
      4'd8:    pattern = 8'h7F;
      4'd9:    pattern = 8'h6F;
      default: pattern = 8'h00;
    endcase
    return pattern;
  endfunction

  // ---------------------------------------------------------------------------
  // Prescaler: a zero period behaves as one, so the terminal value is 0 then.
  // ---------------------------------------------------------------------------
  logic [CYCLE_W-1:0] pre;
  logic [CYCLE_W-1:0] pre_term;
  logic               pre_hit;

  assign pre_term = (cycle == '0) ? '0 : cycle - CYCLE_W'(1);
  assign pre_hit  = en && (pre == pre_term);

  // ---------------------------------------------------------------------------
  // Next count: the carry/borrow ripples through every digit in one pass, and
  // a carry surviving past the top digit is the wrap condition.
  // ---------------------------------------------------------------------------
  logic [4*N_DIGITS-1:0] count_step;
  logic [4*N_DIGITS-1:0] load_clamped;
  logic                  step_carry;

  always_comb begin
    count_step = count;
    step_carry = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (step_carry) begin
        if (up) begin
          if (count[4*i +: 4] == 4'd9) begin
            count_step[4*i +: 4] = 4'd0;
          end else begin
            count_step[4*i +: 4] = count[4*i +: 4] + 4'd1;
            step_carry           = 1'b0;
          end
        end else begin
          if (count[4*i +: 4] == 4'd0) begin
            count_step[4*i +: 4] = 4'd9;
          end else begin
            count_step[4*i +: 4] = count[4*i +: 4] - 4'd1;
            step_carry           = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre   <= '0;
      count <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      debug <= 1'b0;
    end else if (load) begin
      pre   <= '0;
      count <= load_clamped;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else if (pre_hit) begin
      pre   <= '0;
      count <= count_step;
      tick  <= 1'b1;
      wrap  <= step_carry;
      debug <= ~debug;
    end else begin
      if (en) begin
        pre <= pre + CYCLE_W'(1);
      end
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan driver. sel and seg are both built from idx_nxt so they always move
  // together; seg decodes the current count register, hence the one-clock lag.
  // ---------------------------------------------------------------------------
  logic [SEG_W-1:0]    sc;
  logic [SEG_W-1:0]    sc_term;
  logic                sc_hit;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic [N_DIGITS-1:0] sel_nxt;
  logic [3:0]          shown;
  logic                blank;
  logic [7:0]          seg_nxt;

  assign sc_term = (segtiming == '0) ? '0 : segtiming - SEG_W'(1);
  assign sc_hit  = (sc == sc_term);
  assign idx_nxt = !sc_hit ? idx : ((idx == IDX_LAST) ? '0 : idx + IDX_W'(1));
  assign sel_nxt = N_DIGITS'(1) << idx_nxt;

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_above;

  // Walk from the top digit down; a digit is blank while everything above it
  // (and itself) is zero. Digit 0 always shows.
  always_comb begin
    shown      = 4'd0;
    blank      = 1'b0;
    zero_above = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (count[4*i +: 4] == 4'd0);
      if (idx_nxt == IDX_W'(i)) begin
        shown = count[4*i +: 4];
        blank = zero_above && (i != 0);
      end
    end
  end
`else
  always_comb begin
    shown = 4'd0;
    blank = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        shown = count[4*i +: 4];
      end
    end
  end
`endif

  assign seg_nxt = blank ? 8'h00 : seg_decode(shown);

  always_ff @(posedge clk) begin
    if (rst) begin
      sc  <= '0;
      idx <= '0;
      sel <= N_DIGITS'(1);
      seg <= 8'h3F;
    end else begin
      sc  <= sc_hit ? '0 : sc + SEG_W'(1);
      idx <= idx_nxt;
      sel <= sel_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter: table of count vectors plus hand sequences for timing, scan, load/enable/reset corners.
module tb_bcd_scan_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [31:0] cycle;
  logic [15:0] segtiming;
  logic [15:0] count;
  logic        tick;
  logic        wrap;
  logic        debug;
  logic [3:0]  sel;
  logic [7:0]  seg;

  int checks   = 0;
  int failures = 0;

  bcd_scan_counter #(.N_DIGITS(4), .CYCLE_W(32), .SEG_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_val  (load_val),
    .cycle     (cycle),
    .segtiming (segtiming),
    .count     (count),
    .tick      (tick),
    .wrap      (wrap),
    .debug     (debug),
    .sel       (sel),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [15:0] load_val;
    logic        en;
    logic        up;
    logic [31:0] cycle;
    int          n_clk;
    logic [15:0] exp_count;
    logic        exp_tick;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[17];

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] ZERO_HI = 8'h00;
`else
  localparam logic [7:0] ZERO_HI = 8'h3F;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then settle on the falling edge for sampling/driving.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic scan_check(input string name, input logic [7:0] exp_seg[4]);
    int d;
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk({name, "_onehot"}, $onehot(sel), 1);
      d = 0;
      for (int i = 0; i < 4; i++) if (sel[i]) d = i;
      chk({name, "_seg"}, seg, exp_seg[d]);
    end
  endtask

  initial begin
    logic [7:0] exp_seg[4];
    logic [3:0] last_sel;
    int         sel_changes;
    int         d;

    //        load lv       en up cyc n  count    tk wr
    vecs[0]  = '{1, 16'h0999, 1, 1, 1, 1, 16'h0999, 0, 0};
    vecs[1]  = '{0, 16'h0000, 1, 1, 1, 1, 16'h1000, 1, 0};
    vecs[2]  = '{1, 16'h0A0F, 1, 1, 1, 1, 16'h0909, 0, 0};
    vecs[3]  = '{0, 16'h0000, 1, 1, 1, 1, 16'h0910, 1, 0};
    vecs[4]  = '{1, 16'h9999, 1, 1, 1, 1, 16'h9999, 0, 0};
    vecs[5]  = '{0, 16'h0000, 1, 1, 1, 1, 16'h0000, 1, 1};
    vecs[6]  = '{0, 16'h0000, 1, 0, 1, 1, 16'h9999, 1, 1};
    vecs[7]  = '{0, 16'h0000, 1, 0, 1, 1, 16'h9998, 1, 0};
    vecs[8]  = '{0, 16'h0000, 0, 0, 1, 3, 16'h9998, 0, 0};
    vecs[9]  = '{1, 16'h0100, 0, 0, 1, 1, 16'h0100, 0, 0};
    vecs[10] = '{0, 16'h0000, 1, 0, 1, 1, 16'h0099, 1, 0};
    vecs[11] = '{0, 16'h0000, 1, 1, 0, 1, 16'h0100, 1, 0};
    vecs[12] = '{0, 16'h0000, 1, 1, 3, 2, 16'h0100, 0, 0};
    vecs[13] = '{0, 16'h0000, 1, 1, 3, 1, 16'h0101, 1, 0};
    vecs[14] = '{1, 16'h1234, 1, 1, 1, 1, 16'h1234, 0, 0};
    vecs[15] = '{1, 16'hF0A5, 1, 1, 1, 1, 16'h9095, 0, 0};
    vecs[16] = '{0, 16'h0000, 1, 0, 1, 1, 16'h9094, 1, 0};

    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
    cycle = 32'd4; segtiming = 16'd2;
    step(2);

    chk("rst_count", count, 16'h0000);
    chk("rst_tick",  tick,  0);
    chk("rst_wrap",  wrap,  0);
    chk("rst_debug", debug, 0);
    chk("rst_sel",   sel,   4'b0001);
    chk("rst_seg",   seg,   8'h3F);

    // First tick 4 clocks after release; digits held 2 clocks each.
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      d = (k / 2) % 4;
      chk("t1_count", count, (k >= 8) ? 16'h0002 : (k >= 4) ? 16'h0001 : 16'h0000);
      chk("t1_tick",  tick,  (k == 4 || k == 8) ? 1 : 0);
      chk("t1_wrap",  wrap,  0);
      chk("t1_debug", debug, (k >= 4 && k < 8) ? 1 : 0);
      chk("t1_sel",   sel,   4'b0001 << d);
      if (d != 0)      chk("t1_seg", seg, ZERO_HI);
      else if (k == 8) chk("t1_seg", seg, 8'h06);
      else if (k == 9) chk("t1_seg", seg, 8'h5B);
      else             chk("t1_seg", seg, 8'h3F);
    end

    // Load wins over a tick landing on the same edge.
    step(2);
    load = 1'b1; load_val = 16'h0555;
    step(1);
    chk("t4_load_count", count, 16'h0555);
    chk("t4_load_tick",  tick,  0);
    chk("t4_load_wrap",  wrap,  0);
    chk("t4_load_debug", debug, 0);
    load = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      step(1);
      chk("t4_next_tick",  tick,  (j == 4) ? 1 : 0);
      chk("t4_next_count", count, (j == 4) ? 16'h0556 : 16'h0555);
    end

    // Freeze mid-period: counter/prescaler hold, scan keeps running.
    step(1);
    en = 1'b0;
    last_sel = sel;
    sel_changes = 0;
    for (int j = 0; j < 10; j++) begin
      step(1);
      chk("t5_frozen_count", count, 16'h0556);
      chk("t5_frozen_tick",  tick,  0);
      if (sel != last_sel) sel_changes++;
      last_sel = sel;
    end
    chk("t5_scan_runs", (sel_changes > 0) ? 1 : 0, 1);
    en = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      step(1);
      chk("t5_resume_tick",  tick,  (j == 3) ? 1 : 0);
      chk("t5_resume_count", count, (j == 3) ? 16'h0557 : 16'h0556);
    end
    step(4);
    chk("t5_pre_rst_count", count, 16'h0558);
    chk("t5_pre_rst_debug", debug, 1);

    rst = 1'b1;
    step(1);
    chk("t5_rst_count", count, 16'h0000);
    chk("t5_rst_sel",   sel,   4'b0001);
    chk("t5_rst_seg",   seg,   8'h3F);
    chk("t5_rst_debug", debug, 0);
    chk("t5_rst_tick",  tick,  0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      load     = vecs[i].load;
      load_val = vecs[i].load_val;
      en       = vecs[i].en;
      up       = vecs[i].up;
      cycle    = vecs[i].cycle;
      step(vecs[i].n_clk);
      chk($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
      chk($sformatf("vec%0d_tick", i),  tick,  vecs[i].exp_tick);
      chk($sformatf("vec%0d_wrap", i),  wrap,  vecs[i].exp_wrap);
    end

    // Static display patterns with fast scanning.
    en = 1'b0; segtiming = 16'd1;
    load = 1'b1; load_val = 16'h0042;
    step(1);
    load = 1'b0;
    step(2);
    exp_seg[0] = 8'h5B; exp_seg[1] = 8'h66; exp_seg[2] = ZERO_HI; exp_seg[3] = ZERO_HI;
    scan_check("t6_0042", exp_seg);

    load = 1'b1; load_val = 16'h0000;
    step(1);
    load = 1'b0;
    step(2);
    exp_seg[0] = 8'h3F; exp_seg[1] = ZERO_HI; exp_seg[2] = ZERO_HI; exp_seg[3] = ZERO_HI;
    scan_check("t6_0000", exp_seg);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
